uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx.sv | 107 ++++++++++
 tb/tb_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period, LSU protocol bytes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CLEANUP
    } uart_state_t;

    localparam int UART_CLKS_PER_BIT = 16;

    // First byte of every LSU store transaction.
    localparam logic [7:0] LSU_FLAG_BYTE = 8'h03;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, expire is high on the last count.
// Latency: expire is combinational from the registered count; wraps to 0 on expire.
// Backpressure: none; clear holds the count at 0 for as long as it is asserted.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expire
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing; UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// Latency: line falls the cycle after accept; tx_done pulses 10 (11 with parity) bit periods later.
// Backpressure: active-low tx_start is sampled only in IDLE; the requester advances on tx_done.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);
    uart_state_t state, state_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        serial_nxt;
    logic        timer_clr;
    logic        bit_expire;

    // Counter is parked at zero outside the timed states so START always gets a full period.
    assign timer_clr = (state == IDLE) || (state == CLEANUP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clr),
        .expire(bit_expire)
    );

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        case (state)
            IDLE: begin
                if (!tx_start) begin
                    shift_nxt   = tx_data;
                    bit_idx_nxt = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_expire) state_nxt = DATA;
            end
            DATA: begin
                if (bit_expire) begin
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_expire) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_expire) state_nxt = CLEANUP;
            end
            CLEANUP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so the line value is derived from the state being entered.
    always_comb begin
        serial_nxt = 1'b1;
        case (state_nxt)
            START:   serial_nxt = 1'b0;
            DATA:    serial_nxt = shift_nxt[bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_nxt = ^shift_nxt;
`endif
            default: serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift     <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            tx_serial <= serial_nxt;
            tx_busy   <= (state_nxt != IDLE);
            tx_done   <= (state_nxt == CLEANUP);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: expected frames built from the byte, compared bit by bit.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       tx_start = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int cyc        = 0;
    int n_tests    = 0;
    int n_fail     = 0;
    int n_done     = 0;
    int accept_cyc = 0;

    logic [7:0] lsu_seq [4] = '{LSU_FLAG_BYTE, 8'h10, 8'h12, 8'h34};

    uart_tx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (tx_done === 1'b1) n_done <= n_done + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected line bits, index 0 is the start bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Call at a negedge while the DUT is idle.
    task automatic launch(input logic [7:0] d, input bit pulse);
        tx_data    = d;
        tx_start   = 1'b0;
        accept_cyc = cyc;
        if (pulse) begin
            fork
                begin
                    @(negedge clk);
                    tx_start = 1'b1;
                end
            join_none
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input bit chk_lat, output int done_cyc);
        logic [10:0] fb;
        bit          found;
        logic        busy_bad;
        logic        done_bad;
        int          start_cyc;
        fb       = frame_bits(d);
        found    = 1'b0;
        busy_bad = 1'b0;
        done_bad = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) found = 1'b1;
        end
        if (!found) begin
            check("start_timeout", 32'(found), 1);
            return;
        end
        start_cyc = cyc;
        if (chk_lat) check("accept_latency", 32'(start_cyc - accept_cyc), 1);
        for (int b = 0; b < FL; b++) begin
            logic got;
            got = fb[b];
            for (int c = 0; c < N; c++) begin
                if (tx_serial !== fb[b]) got = tx_serial;
                if (tx_busy !== 1'b1) busy_bad = 1'b1;
                if (tx_done !== 1'b0) done_bad = 1'b1;
                @(negedge clk);
            end
            check($sformatf("bit%0d_of_%02h", b, d), 32'(got), 32'(fb[b]));
        end
        check("busy_in_frame", 32'(busy_bad), 0);
        check("done_in_frame", 32'(done_bad), 0);
        done_cyc = cyc;
        check("done_pulse", 32'(tx_done), 1);
        check("busy_cleanup", 32'(tx_busy), 1);
        check("serial_cleanup", 32'(tx_serial), 1);
        @(negedge clk);
        check("done_single", 32'(tx_done), 0);
        check("busy_idle", 32'(tx_busy), 0);
    endtask

    initial begin
        int         dc0;
        int         dc1;
        int         snap;
        int         delay;
        logic       bad;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("rst_serial", 32'(tx_serial), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_done", 32'(tx_done), 0);
        reset = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("idle_serial", 32'(tx_serial), 1);
        check("idle_busy", 32'(tx_busy), 0);

        snap = n_done;
        launch(8'hA5, 1'b1);
        rx_frame(8'hA5, 1'b1, dc0);
        check("a5_done_count", 32'(n_done - snap), 1);

        // Held-low request, data advanced after each tx_done.
        snap = n_done;
        launch(8'h03, 1'b0);
        rx_frame(8'h03, 1'b1, dc0);
        tx_data = 8'h42;
        rx_frame(8'h42, 1'b0, dc1);
        tx_start = 1'b1;
        check("gap_03_42", 32'(dc1 - dc0 - FL * N), 2);
        check("b2b_done_count", 32'(n_done - snap), 2);

        snap = n_done;
        launch(8'h00, 1'b1);
        fork
            begin
                repeat ((1 + 4) * N + 1) @(negedge clk);
                tx_data = 8'hFF;
            end
        join_none
        rx_frame(8'h00, 1'b1, dc0);

        for (int k = 0; k < 6; k++) begin
            d     = 8'($urandom);
            delay = int'($urandom_range(1, FL * N));
            launch(d, 1'b1);
            fork
                begin
                    repeat (delay) @(negedge clk);
                    tx_data = 8'($urandom);
                end
            join_none
            rx_frame(d, 1'b1, dc0);
        end

        // LSU store: flag, address, data high, data low.
        snap = n_done;
        launch(lsu_seq[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            dc1 = dc0;
            rx_frame(lsu_seq[k], k == 0, dc0);
            if (k > 0) check("lsu_gap", 32'(dc0 - dc1 - FL * N), 2);
            if (k < 3) tx_data = lsu_seq[k + 1];
        end
        tx_start = 1'b1;
        bad = 1'b0;
        repeat (3 * FL * N) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("no_fifth_frame", 32'(bad), 0);
        check("lsu_done_count", 32'(n_done - snap), 4);

        // Asynchronous reset in the middle of the data bits.
        snap = n_done;
        launch(8'h00, 1'b1);
        repeat (3 * N) @(negedge clk);
        check("pre_reset_low", 32'(tx_serial), 0);
        #2 reset = 1'b0;
        #1;
        check("arst_serial", 32'(tx_serial), 1);
        check("arst_busy", 32'(tx_busy), 0);
        check("arst_done", 32'(tx_done), 0);
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (FL * N) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("post_reset_idle", 32'(bad), 0);
        check("reset_done_count", 32'(n_done - snap), 0);
        launch(8'hC3, 1'b1);
        rx_frame(8'hC3, 1'b1, dc0);

        // 8'h07 has odd popcount, so the parity bit is 1 when parity framing is built in.
        launch(8'h07, 1'b1);
        rx_frame(8'h07, 1'b1, dc0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
